// File: rtl/sc_io_stim_gen.sv
// Reset sequencer, stepped input-port pattern generator and output-port snapshot for the single-cycle computer.
// Build option: define STIM_SNAP_PERIODIC_EN for repeating captures plus a snap_count output.
module sc_io_stim_gen #(
  parameter int          WIDTH       = 32,
  parameter int          CHANNELS    = 2,
  parameter int          OUT_PORTS   = 3,
  parameter int          MODULUS     = 9,
  parameter int          STEP_CYCLES = 5,
  parameter int          RESET_HOLD  = 2,
  parameter int          SNAP_CYCLE  = 31250,
  parameter logic [31:0] LFSR_SEED   = 32'h1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  output logic                       cpu_resetn,
  output logic [CHANNELS*WIDTH-1:0]  in_port_bus,
  output logic                       step_pulse,
  input  logic [OUT_PORTS*WIDTH-1:0] out_port_bus,
  output logic [OUT_PORTS*WIDTH-1:0] snap_data,
  output logic                       snap_valid,
  output logic [31:0]                cycle_count
`ifdef STIM_SNAP_PERIODIC_EN
  ,
  output logic [15:0]                snap_count
`endif
);

  // state   | meaning
  // ST_HOLD | computer held in reset for RESET_HOLD cycles after reset release
  // ST_RUN  | computer running; stepping, cycle count and snapshot active (terminal)
  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_HOLD = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;

  localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int                PRE_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
  localparam logic [WIDTH-1:0]  RAMP_LAST = WIDTH'(MODULUS - 1);
  localparam logic [31:0]       SNAP_LAST = 32'(SNAP_CYCLE - 1);
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;

  logic [0:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  chan [CHANNELS];
  logic              run;
  logic              step;

  assign run        = (state == ST_RUN);
  assign step       = run && enable && (pre_cnt == PRE_LAST);
  assign step_pulse = step;

  function automatic logic [31:0] to32(input logic [WIDTH-1:0] v);
    logic [WIDTH+31:0] e;
    e            = '0;
    e[WIDTH-1:0] = v;
    return e[31:0];
  endfunction

  function automatic logic [WIDTH-1:0] from32(input logic [31:0] s);
    logic [WIDTH+31:0] e;
    e        = '0;
    e[31:0]  = s;
    return e[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] chan_seed(input int k);
    logic [31:0] s;
    s = LFSR_SEED ^ 32'(k);
    if (s == 32'h0) s = 32'h1;
    return from32(s);
  endfunction

  // LFSR state lives in the channel value itself, so entering LFSR mode reseeds.
  function automatic logic [WIDTH-1:0] chan_next(input logic [WIDTH-1:0] v, input logic [1:0] m,
                                                 input logic [1:0] m_prev, input int k);
    logic [31:0]      s;
    logic [WIDTH-1:0] r;
    s = to32(v);
    r = v;
    case (m)
      MODE_RAMP: r = (v >= RAMP_LAST) ? '0 : v + WIDTH'(1);
      MODE_HOLD: r = v;
      MODE_LFSR: r = (m_prev != MODE_LFSR) ? chan_seed(k)
                                           : from32((s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0));
      MODE_WALK: r = ((v == '0) || v[WIDTH-1]) ? WIDTH'(1) : (v << 1);
      default:   r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      cpu_resetn <= 1'b0;
    end else if (state == ST_HOLD) begin
      if (hold_cnt == HOLD_LAST) begin
        state      <= ST_RUN;
        cpu_resetn <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (run && enable) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_RAMP;
      for (int k = 0; k < CHANNELS; k++) chan[k] <= '0;
    end else if (step) begin
      mode_q <= mode;
      for (int k = 0; k < CHANNELS; k++) chan[k] <= chan_next(chan[k], mode, mode_q, k);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_bus
    assign in_port_bus[k*WIDTH +: WIDTH] = chan[k];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (run && (cycle_count != 32'hFFFF_FFFF)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

`ifdef STIM_SNAP_PERIODIC_EN
  logic [31:0] snap_tmr;

  // Down-counter tracks cycle_count modulo SNAP_CYCLE, unaffected by saturation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_tmr   <= SNAP_LAST;
      snap_data  <= '0;
      snap_valid <= 1'b0;
      snap_count <= '0;
    end else if (run) begin
      if (snap_tmr == 32'h0) begin
        snap_tmr   <= SNAP_LAST;
        snap_data  <= out_port_bus;
        snap_valid <= 1'b1;
        snap_count <= snap_count + 16'd1;
      end else begin
        snap_tmr   <= snap_tmr - 32'd1;
        snap_valid <= 1'b0;
      end
    end else begin
      snap_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_data  <= '0;
      snap_valid <= 1'b0;
    end else if (run && !snap_valid && (cycle_count == SNAP_LAST)) begin
      snap_data  <= out_port_bus;
      snap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sc_io_stim_gen.sv
// Self-checking bench for sc_io_stim_gen: reset sequencing, pattern modes, enable gating, snapshot, async reset.
module tb_sc_io_stim_gen;
  localparam int          W    = 32;
  localparam int          CH   = 2;
  localparam int          OUTP = 3;
  localparam int          MOD  = 9;
  localparam int          STEP = 5;
  localparam int          RH   = 2;
  localparam int          SNAP = 20;
  localparam logic [31:0] SEED = 32'h1;

  logic                clock  = 1'b0;
  logic                reset  = 1'b1;
  logic                enable = 1'b0;
  logic [1:0]          mode   = 2'd0;
  logic                cpu_resetn;
  logic [CH*W-1:0]     in_port_bus;
  logic                step_pulse;
  logic [OUTP*W-1:0]   out_port_bus = '0;
  logic [OUTP*W-1:0]   snap_data;
  logic                snap_valid;
  logic [31:0]         cycle_count;
`ifdef STIM_SNAP_PERIODIC_EN
  logic [15:0]         snap_count;
`endif

  int errors = 0;
  int checks = 0;
  int n = 0;

  logic [W-1:0]      exp_q [$];
  logic [OUTP*W-1:0] snap_q [$];
  logic [W-1:0]      mdl [CH];
  logic [1:0]        mdl_mode;

  always #5 clock = ~clock;

  sc_io_stim_gen #(
    .WIDTH(W), .CHANNELS(CH), .OUT_PORTS(OUTP), .MODULUS(MOD), .STEP_CYCLES(STEP),
    .RESET_HOLD(RH), .SNAP_CYCLE(SNAP), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock),
`ifdef STIM_SNAP_PERIODIC_EN
    .snap_count(snap_count),
`endif
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .cpu_resetn(cpu_resetn),
    .in_port_bus(in_port_bus),
    .step_pulse(step_pulse),
    .out_port_bus(out_port_bus),
    .snap_data(snap_data),
    .snap_valid(snap_valid),
    .cycle_count(cycle_count)
  );

  function automatic logic [OUTP*W-1:0] bus_at(input int t);
    logic [OUTP*W-1:0] r;
    r = '0;
    for (int j = 0; j < OUTP; j++) r[j*W +: W] = {t[23:0], 8'h00} | W'(j + 1);
    return r;
  endfunction

  function automatic logic [W-1:0] model_next(input logic [W-1:0] v, input logic [1:0] m,
                                              input logic [1:0] prev, input int k);
    logic [32:0] t;
    logic [31:0] s;
    logic [W-1:0] r;
    r = v;
    case (m)
      2'd0: begin
        t = {1'b0, v} + 33'd1;
        r = (t >= 33'(MOD)) ? '0 : t[31:0];
      end
      2'd1: r = v;
      2'd2: begin
        if (prev != 2'd2) begin
          s = SEED ^ 32'(k);
          r = (s == 32'h0) ? 32'h1 : s;
        end else begin
          s = {v[0], v[31:1]};
          s[21] = s[21] ^ v[0];
          s[1]  = s[1] ^ v[0];
          s[0]  = s[0] ^ v[0];
          r = s;
        end
      end
      default: r = ((v == '0) || v[31]) ? 32'h1 : {v[30:0], 1'b0};
    endcase
    return r;
  endfunction

  task automatic tick;
    @(negedge clock);
    n = n + 1;
    out_port_bus = bus_at(n);
  endtask

  task automatic model_clear;
    for (int k = 0; k < CH; k++) mdl[k] = '0;
    mdl_mode = 2'd0;
    exp_q.delete();
    snap_q.delete();
  endtask

  // Leaves the bench at the negedge where cpu_resetn has just gone high (n == RH).
  task automatic release_reset;
    reset = 1'b1;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < RH; i++) tick();
  endtask

  task automatic wait_step(output int cnt);
    cnt = 0;
    while (step_pulse !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    if (step_pulse !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL step_timeout got step_pulse=%b exp=1 after %0d cycles", step_pulse, cnt);
    end
  endtask

  task automatic do_step(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int k = 0; k < CH; k++) begin
      e = model_next(mdl[k], mode, mdl_mode, k);
      exp_q.push_back(e);
      mdl[k] = e;
    end
    mdl_mode = mode;
    tick();
    for (int k = 0; k < CH; k++) begin
      got = in_port_bus[k*W +: W];
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s ch%0d got=%h exp=%h (n=%0d)", tag, k, got, e, n);
      end
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    enable = 1'b1;
    mode   = 2'd0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({cpu_resetn, in_port_bus, step_pulse, snap_data, snap_valid, cycle_count} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got cpu_resetn=%b bus=%h step=%b snap_valid=%b cycle=%0d exp all 0",
                 cpu_resetn, in_port_bus, step_pulse, snap_valid, cycle_count);
      end
    end
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= RH; i++) begin
      tick();
      checks++;
      if (cpu_resetn !== (i == RH)) begin
        errors++;
        $display("FAIL release_cpu_resetn cycle %0d got=%b exp=%b", i, cpu_resetn, (i == RH));
      end
    end
    checks++;
    if (cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL cycle_count_at_release got=%0d exp=0", cycle_count);
    end
    tick();
    checks++;
    if (cycle_count !== 32'd1) begin
      errors++;
      $display("FAIL cycle_count_first_run got=%0d exp=1", cycle_count);
    end
  endtask

  task automatic test_ramp;
    int cnt;
    mode = 2'd0;
    enable = 1'b1;
    release_reset();
    for (int s = 0; s < 10; s++) begin
      wait_step(cnt);
      checks++;
      if (cnt !== STEP - 1) begin
        errors++;
        $display("FAIL ramp_interval step %0d got=%0d exp=%0d", s, cnt, STEP - 1);
      end
      do_step("ramp");
      checks++;
      if (step_pulse !== 1'b0) begin
        errors++;
        $display("FAIL step_pulse_width got=%b exp=0", step_pulse);
      end
    end
    checks++;
    if (cycle_count !== 32'(n - RH)) begin
      errors++;
      $display("FAIL ramp_cycle_count got=%0d exp=%0d", cycle_count, n - RH);
    end
  endtask

  task automatic test_enable_gating;
    int cnt;
    mode = 2'd0;
    enable = 1'b1;
    release_reset();
    for (int s = 0; s < 4; s++) begin
      wait_step(cnt);
      do_step("gate_ramp");
    end
    tick();
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (step_pulse !== 1'b0 || in_port_bus[W-1:0] !== mdl[0]) begin
        errors++;
        $display("FAIL gated_hold got step=%b val=%0d exp step=0 val=%0d", step_pulse, in_port_bus[W-1:0], mdl[0]);
      end
    end
    enable = 1'b1;
    wait_step(cnt);
    checks++;
    if (cnt !== STEP - 2) begin
      errors++;
      $display("FAIL reenable_remaining got=%0d exp=%0d", cnt, STEP - 2);
    end
    do_step("reenable");
    checks++;
    if (cycle_count !== 32'(n - RH)) begin
      errors++;
      $display("FAIL gated_cycle_count got=%0d exp=%0d", cycle_count, n - RH);
    end
  endtask

  task automatic test_mode_switch;
    int cnt;
    mode = 2'd0;
    enable = 1'b1;
    release_reset();
    for (int s = 0; s < 3; s++) begin
      wait_step(cnt);
      do_step("switch_ramp");
    end
    tick();
    mode = 2'd1;
    tick();
    checks++;
    if (in_port_bus[W-1:0] !== mdl[0]) begin
      errors++;
      $display("FAIL mode_mid_interval got=%0d exp=%0d", in_port_bus[W-1:0], mdl[0]);
    end
    mode = 2'd3;
    for (int s = 0; s < 32; s++) begin
      wait_step(cnt);
      do_step("walk");
      if (s == 30) begin
        checks++;
        if (in_port_bus[W-1:0] !== 32'h1) begin
          errors++;
          $display("FAIL walk_msb_wrap got=%h exp=00000001", in_port_bus[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_lfsr;
    int cnt;
    int zero_seen;
    zero_seen = 0;
    mode = 2'd2;
    enable = 1'b1;
    release_reset();
    for (int s = 0; s < 1000; s++) begin
      wait_step(cnt);
      do_step("lfsr");
      if (s == 0) begin
        checks++;
        if (in_port_bus[W +: W] !== 32'h1) begin
          errors++;
          $display("FAIL lfsr_forced_seed got=%h exp=00000001", in_port_bus[W +: W]);
        end
      end
      for (int k = 0; k < CH; k++) if (in_port_bus[k*W +: W] == '0) zero_seen++;
    end
    checks++;
    if (zero_seen !== 0) begin
      errors++;
      $display("FAIL lfsr_nonzero got=%0d zero values exp=0", zero_seen);
    end
    mode = 2'd1;
    for (int s = 0; s < 2; s++) begin wait_step(cnt); do_step("hold"); end
    mode = 2'd0;
    wait_step(cnt);
    do_step("ramp_from_large");
    mode = 2'd3;
    wait_step(cnt);
    do_step("walk_from_ramp");
    mode = 2'd2;
    wait_step(cnt);
    do_step("lfsr_reseed");
  endtask

  task automatic test_snapshot;
    logic [OUTP*W-1:0] e;
    int snap_n;
    snap_n = SNAP - 1 + RH;
    mode = 2'd1;
    enable = 1'b1;
    release_reset();
    while (n < snap_n) tick();
    checks++;
    if (snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL snap_early got=%b exp=0", snap_valid);
    end
    snap_q.push_back(bus_at(n));
    tick();
    e = snap_q.pop_front();
    checks++;
    if (snap_valid !== 1'b1 || snap_data !== e) begin
      errors++;
      $display("FAIL snap_capture got valid=%b data=%h exp valid=1 data=%h", snap_valid, snap_data, e);
    end
`ifdef STIM_SNAP_PERIODIC_EN
    tick();
    checks++;
    if (snap_valid !== 1'b0 || snap_count !== 16'd1) begin
      errors++;
      $display("FAIL snap_pulse got valid=%b count=%0d exp valid=0 count=1", snap_valid, snap_count);
    end
    while (n < snap_n + SNAP) tick();
    snap_q.push_back(bus_at(n));
    tick();
    e = snap_q.pop_front();
    checks++;
    if (snap_valid !== 1'b1 || snap_data !== e || snap_count !== 16'd2) begin
      errors++;
      $display("FAIL snap_repeat got valid=%b data=%h count=%0d exp valid=1 data=%h count=2",
               snap_valid, snap_data, snap_count, e);
    end
`else
    while (n < snap_n + SNAP + 2) tick();
    checks++;
    if (snap_valid !== 1'b1 || snap_data !== e) begin
      errors++;
      $display("FAIL snap_sticky got valid=%b data=%h exp valid=1 data=%h", snap_valid, snap_data, e);
    end
`endif
  endtask

  task automatic test_async_reset;
    int cnt;
    mode = 2'd0;
    enable = 1'b1;
    release_reset();
    for (int s = 0; s < 3; s++) begin
      wait_step(cnt);
      do_step("pre_reset_ramp");
    end
    while (n < 17 + RH) tick();
    checks++;
    if (cycle_count !== 32'd17) begin
      errors++;
      $display("FAIL pre_reset_cycle got=%0d exp=17", cycle_count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_resetn, in_port_bus, step_pulse, snap_valid, cycle_count} !== '0) begin
      errors++;
      $display("FAIL async_reset got cpu_resetn=%b bus=%h step=%b snap_valid=%b cycle=%0d exp all 0",
               cpu_resetn, in_port_bus, step_pulse, snap_valid, cycle_count);
    end
    release_reset();
    checks++;
    if (cpu_resetn !== 1'b1 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL restart_release got cpu_resetn=%b cycle=%0d exp 1 and 0", cpu_resetn, cycle_count);
    end
    wait_step(cnt);
    checks++;
    if (cnt !== STEP - 1) begin
      errors++;
      $display("FAIL restart_interval got=%0d exp=%0d", cnt, STEP - 1);
    end
    do_step("restart_ramp");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_enable_gating();
    test_mode_switch();
    test_lfsr();
    test_snapshot();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
